// File: rtl/axi_hdr_pkg.sv
// Shared types and widths for the AXI-Stream header arbiter.
// Holds the FSM encoding and the packet/watchdog counter widths.
package axi_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    PKT   = 2'd2
  } state_t;

  localparam int PKT_CNT_W = 16;
  localparam int WD_W      = 16;

endpackage

// File: rtl/axi_hdr_rr_pick.sv
// Combinational round-robin picker for the header arbiter.
// Searches upward from ptr+1 (mod N) for the first active request.
module axi_hdr_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter handing one header at a time to a stream inserter.
// Ownership lasts until the snooped last beat or the packet watchdog fires.
module axi_stream_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int N_REQ        = 4,
  parameter int TO_CYCLES    = 1024,
  localparam int GW          = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WD-1:0]      req_data,
  input  logic [N_REQ*DATA_BYTE_WD-1:0] req_keep,
  input  logic [N_REQ*BYTE_CNT_WD-1:0]  req_cnt,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          valid_insert,
  output logic [DATA_WD-1:0]            data_insert,
  output logic [DATA_BYTE_WD-1:0]       keep_insert,
  output logic [BYTE_CNT_WD-1:0]        byte_insert_cnt,
  input  logic                          ready_insert,
  input  logic                          mon_valid_out,
  input  logic                          mon_ready_out,
  input  logic                          mon_last_out,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [15:0]                   pkt_cnt,
  output logic                          to_err
);

  state_t                  state_q, state_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [GW-1:0]           gid_q, gid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d;
  logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    err_q, err_d;

  logic [N_REQ-1:0] gnt;
  logic [GW-1:0]    win;
  logic             any;
  logic             beat;
  logic             last;

  axi_hdr_rr_pick #(
    .N  (N_REQ),
    .IW (GW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign beat = mon_valid_out & mon_ready_out;
  assign last = beat & mon_last_out;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    data_d    = data_q;
    keep_d    = keep_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    wd_d      = wd_q;
    err_d     = err_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          // req_ready is masked in reset so nothing looks accepted
          req_ready = rst_n ? gnt : '0;
          gid_d     = win;
          state_d   = OFFER;
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              data_d = req_data[i*DATA_WD +: DATA_WD];
              keep_d = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
              cnt_d  = req_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
            end
          end
        end
      end
      OFFER: begin
        if (ready_insert) begin
          if (last) begin
            state_d   = IDLE;
            ptr_d     = gid_q;
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
          end else begin
            state_d = PKT;
            wd_d    = '0;
          end
        end
      end
      PKT: begin
        if (last) begin
          state_d   = IDLE;
          ptr_d     = gid_q;
          pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
        end else if (beat) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TO_CYCLES - 1)) begin
          state_d = IDLE;
          ptr_d   = gid_q;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= GW'(N_REQ - 1);
      gid_q     <= '0;
      data_q    <= '0;
      keep_q    <= '0;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  assign valid_insert    = (state_q == OFFER);
  assign busy            = (state_q != IDLE);
  assign data_insert     = data_q;
  assign keep_insert     = keep_q;
  assign byte_insert_cnt = cnt_q;
  assign grant_id        = gid_q;
  assign pkt_cnt         = pkt_cnt_q;
  assign to_err          = err_q;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Self-checking bench for axi_stream_header_arbiter.
// Directed scenarios followed by randomized traffic against a packet model.
module tb_axi_stream_header_arbiter;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 2;
  localparam int N  = 4;
  localparam int GW = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*KW-1:0] req_keep;
  logic [N*CW-1:0] req_cnt;
  logic [N-1:0]    req_ready;
  logic            valid_insert;
  logic [DW-1:0]   data_insert;
  logic [KW-1:0]   keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic            ready_insert;
  logic            mon_valid_out;
  logic            mon_ready_out;
  logic            mon_last_out;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic [15:0]     pkt_cnt;
  logic            to_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;
  bit preload = 1'b0;

  always #5 clk = ~clk;

  axi_stream_header_arbiter #(
    .DATA_WD   (DW),
    .N_REQ     (N),
    .TO_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_keep        (req_keep),
    .req_cnt         (req_cnt),
    .req_ready       (req_ready),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .mon_valid_out   (mon_valid_out),
    .mon_ready_out   (mon_ready_out),
    .mon_last_out    (mon_last_out),
    .grant_id        (grant_id),
    .busy            (busy),
    .pkt_cnt         (pkt_cnt),
    .to_err          (to_err)
  );

  // Packet-level model: 0 = free, 1 = header offered, 2 = packet running
  int          m_ph    = 0;
  int          m_ptr   = N - 1;
  int          m_gid   = 0;
  int          m_quiet = 0;
  logic [DW-1:0] m_data = '0;
  logic [KW-1:0] m_keep = '0;
  logic [CW-1:0] m_cnt  = '0;
  logic [15:0]   m_pkts = '0;
  logic          m_err  = 1'b0;
  logic          m_fresh = 1'b1;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int w;
    logic [N-1:0] er;
    logic lst;
    if (started) begin
      w  = pick(req_valid, m_ptr);
      er = '0;
      if (rst_n && m_ph == 0 && w >= 0) er[w] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("valid_insert", valid_insert, m_ph == 1);
      chk("busy", busy, m_ph != 0);
      chk("pkt_cnt", pkt_cnt, m_pkts);
      chk("to_err", to_err, m_err);
      if (m_ph == 1 || m_fresh) begin
        chk("data_insert", data_insert, m_data);
        chk("keep_insert", keep_insert, m_keep);
        chk("byte_cnt", byte_insert_cnt, m_cnt);
      end
      if (m_ph != 0 || m_fresh) chk("grant_id", grant_id, m_gid);
      lst = mon_valid_out && mon_ready_out && mon_last_out;
      if (!rst_n) begin
        m_ph = 0; m_ptr = N - 1; m_gid = 0; m_quiet = 0;
        m_data = '0; m_keep = '0; m_cnt = '0;
        m_pkts = '0; m_err = 1'b0; m_fresh = 1'b1;
      end else begin
        if (preload) m_pkts = 16'hFFFF;
        case (m_ph)
          0: if (w >= 0) begin
            m_ph = 1; m_gid = w; m_fresh = 1'b0;
            m_data = req_data[w*DW +: DW];
            m_keep = req_keep[w*KW +: KW];
            m_cnt  = req_cnt[w*CW +: CW];
          end
          1: if (ready_insert) begin
            if (lst) begin
              m_ph = 0; m_ptr = m_gid; m_pkts++;
            end else begin
              m_ph = 2; m_quiet = 0;
            end
          end
          default: begin
            if (lst) begin
              m_ph = 0; m_ptr = m_gid; m_pkts++;
            end else if (mon_valid_out && mon_ready_out) begin
              m_quiet = 0;
            end else if (m_quiet + 1 == TO) begin
              m_err = 1'b1; m_ph = 0; m_ptr = m_gid;
            end else begin
              m_quiet++;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rnd_hdr();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    req_keep = 16'($urandom);
    req_cnt  = 8'($urandom);
  endtask

  task automatic mon(input logic v);
    mon_valid_out = v;
    mon_ready_out = v;
    mon_last_out  = v;
  endtask

  initial begin
    int seen;
    int gids [5];
    rst_n = 1'b0;
    req_valid = '1;
    rnd_hdr();
    ready_insert = 1'b0;
    mon(1'b0);
    @(posedge clk);
    started = 1'b1;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", valid_insert, 0);
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);

    rst_n = 1'b1;
    ready_insert = 1'b1;
    mon(1'b1);
    seen = 0;
    for (int c = 0; c < 40 && seen < 5; c++) begin
      tick();
      rnd_hdr();
      if (valid_insert) begin
        gids[seen] = int'(grant_id);
        seen++;
        if (seen == 5) req_valid = '0;
      end
    end
    chk("rr_count", seen, 5);
    chk("rr_g0", gids[0], 0);
    chk("rr_g1", gids[1], 1);
    chk("rr_g2", gids[2], 2);
    chk("rr_g3", gids[3], 3);
    chk("rr_g4", gids[4], 0);
    tick();
    chk("rr_pkt_cnt", pkt_cnt, 5);

    mon(1'b0);
    ready_insert = 1'b0;
    req_data[2*DW +: DW] = 32'hA5A5A5A5;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    for (int i = 0; i < 7; i++) begin
      rnd_hdr();
      chk("stall_valid", valid_insert, 1);
      chk("stall_data", data_insert, 32'hA5A5A5A5);
      chk("stall_gid", grant_id, 2);
      tick();
    end
    ready_insert = 1'b1;
    tick();
    ready_insert = 1'b0;
    chk("stall_pkt_busy", busy, 1);
    chk("stall_pkt_valid", valid_insert, 0);
    mon(1'b1);
    tick();
    mon(1'b0);
    chk("stall_done", busy, 0);
    chk("stall_pkt_cnt", pkt_cnt, 6);

    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("sim_gid", grant_id, 1);
    ready_insert = 1'b1;
    mon(1'b1);
    tick();
    ready_insert = 1'b0;
    mon(1'b0);
    chk("sim_idle", busy, 0);
    chk("sim_pkt_cnt", pkt_cnt, 7);

    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    ready_insert = 1'b1;
    tick();
    ready_insert = 1'b0;
    repeat (15) tick();
    chk("wd_early_err", to_err, 0);
    chk("wd_early_busy", busy, 1);
    tick();
    chk("wd_err", to_err, 1);
    chk("wd_idle", busy, 0);
    chk("wd_pkt_cnt", pkt_cnt, 7);

    force dut.pkt_cnt_d = 16'hFFFF;
    preload = 1'b1;
    tick();
    release dut.pkt_cnt_d;
    preload = 1'b0;
    chk("wrap_preload", pkt_cnt, 16'hFFFF);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("wrap_gid", grant_id, 0);
    ready_insert = 1'b1;
    mon(1'b1);
    tick();
    ready_insert = 1'b0;
    mon(1'b0);
    chk("wrap_pkt_cnt", pkt_cnt, 0);
    chk("wrap_err_sticky", to_err, 1);

    for (int c = 0; c < 3000; c++) begin
      bit quiet;
      quiet = ((c / 64) % 3) == 2;
      rst_n = ($urandom % 250) != 0;
      req_valid = 4'($urandom);
      rnd_hdr();
      ready_insert = ($urandom % 3) == 0;
      mon_valid_out = quiet ? 1'b0 : 1'($urandom);
      mon_ready_out = 1'($urandom);
      mon_last_out  = ($urandom % 4) == 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
